// File: rtl/pwm_pkg.sv
// Shared constants, clock-divider derivation and FSM state type for the PWM fade controller.
package pwm_pkg;

    localparam int DUTY_MAX = 100;
    localparam int DUTY_W   = 7;

    typedef enum logic {IDLE, RAMP} state_t;

    // Integer division rounded half-up.
    function automatic int unsigned rdiv(input int unsigned a, input int unsigned b);
        int unsigned q;
        q = a / b;
        if (2 * (a % b) >= b) q = q + 1;
        return q;
    endfunction

    function automatic int unsigned calc_cnt_max(input int unsigned clk_mhz,
                                                 input int unsigned freq_khz);
        return rdiv(clk_mhz * 1000, freq_khz);
    endfunction

    // Fixed-point (Q16) scale turning a percent duty into period counts.
    function automatic int unsigned calc_k(input int unsigned cnt_max);
        return rdiv(cnt_max * 65536, 100);
    endfunction

endpackage

// File: rtl/pwm_period_gen.sv
// Free-running PWM period counter with a load-strobed compare register and registered output.
module pwm_period_gen
    import pwm_pkg::*;
#(
    parameter int CNT_MAX = 125,
    parameter int CNT_W   = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CNT_W:0] cmp_next,
    input  logic           load,
    output logic           wrap,
    output logic           pwm_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cmp_p1;

    assign wrap = (cnt == CNT_W'(CNT_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            cmp_p1  <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (load) cmp_p1 <= cmp_next;
            // Output stage: one cycle behind cnt; cmp_p1 one bit wider so 100 % stays high.
            pwm_out <= ({1'b0, cnt} < cmp_p1);
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM generator whose duty fades one percent per STEP_PERIODS periods toward a commanded target.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int CLK_MHZ      = 50,
    parameter int FREQ_KHZ     = 400,
    parameter int STEP_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              cmd_ready,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] cur_duty,
    output logic              busy,
    output logic              done
);

    localparam int                     CNT_MAX   = int'(calc_cnt_max(CLK_MHZ, FREQ_KHZ));
    localparam int                     CNT_W     = $clog2(CNT_MAX);
    localparam logic [23:0]            K         = 24'(calc_k(CNT_MAX));
    localparam int                     STEP_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [STEP_W-1:0]      STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [DUTY_W-1:0]      DUTY_TOP  = DUTY_W'(DUTY_MAX);
    localparam logic signed [DUTY_W:0] UP        = 1;
    localparam logic signed [DUTY_W:0] DOWN      = -1;

    // Percent to compare threshold, rounded to the nearest count within a 24-bit product.
    function automatic logic [CNT_W:0] duty_to_cmp(input logic [DUTY_W-1:0] duty);
        logic [23:0] prod;
        prod = 24'(duty) * K + 24'd32768;
        return prod[16 +: CNT_W + 1];
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty);
        return (duty > DUTY_TOP) ? DUTY_TOP : duty;
    endfunction

    state_t                  state;
    logic [DUTY_W-1:0]       tgt;
    logic [DUTY_W-1:0]       tgt_req;
    logic [DUTY_W-1:0]       duty_next;
    logic signed [DUTY_W:0]  dir;
    logic signed [DUTY_W:0]  duty_sum;
    logic [STEP_W-1:0]       step_cnt;
    logic                    accept;
    logic                    wrap;
    logic                    step_evt;
    logic [CNT_W:0]          cmp_next;

    assign tgt_req   = clamp_duty(cmd_duty);
    assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
    assign dir       = (tgt > cur_duty) ? UP : DOWN;
    assign duty_sum  = $signed({1'b0, cur_duty}) + dir;
    assign duty_next = DUTY_W'(duty_sum);
    assign step_evt  = (state == RAMP) && wrap && (step_cnt == STEP_LAST);
    // Threshold for the duty being stepped to, loaded on the same edge as cur_duty.
    assign cmp_next  = duty_to_cmp(duty_next);

    pwm_period_gen #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_period (
        .clk      (clk),
        .rst      (rst),
        .cmp_next (cmp_next),
        .load     (step_evt),
        .wrap     (wrap),
        .pwm_out  (pwm_out)
    );

    always_ff @(posedge clk) begin
        if (accept) tgt <= tgt_req;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_duty  <= '0;
            step_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        step_cnt <= '0;
                        if (tgt_req == cur_duty) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RAMP;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (step_evt) begin
                        step_cnt <= '0;
                        cur_duty <= duty_next;
                        if (duty_next == tgt) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (wrap) begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
